// File: rtl/mem_ctrl_burst_if.sv
// Core-side fetch / load-store channels and the byte-wide memory port.
// No latency of its own; slave = controller, master = core plus memory model.
interface mem_ctrl_burst_if #(
  parameter int LINE_BYTES = 4,
  parameter int ADDR_W     = 32
);
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_W-1:0]       mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;
  logic                    if_en;
  logic [ADDR_W-1:0]       if_addr;
  logic                    if_done;
  logic [8*LINE_BYTES-1:0] if_data;
  logic                    lsb_en;
  logic                    lsb_wr;
  logic [ADDR_W-1:0]       lsb_addr;
  logic [2:0]              lsb_len;
  logic [31:0]             lsb_w_data;
  logic                    lsb_done;
  logic [31:0]             lsb_r_data;

  modport slave (
    input  mem_din, io_buffer_full,
    input  if_en, if_addr, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );

  modport master (
    output mem_din, io_buffer_full,
    output if_en, if_addr, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );
endinterface

// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM/IO controller; reads finish N+1 edges after accept, stores one byte per unblocked edge.
// Back-pressure: rdy=0 freezes everything, io_buffer_full stalls IO store bytes indefinitely.
module mem_ctrl_burst #(
  parameter int              LINE_BYTES = 4,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] IO_BASE  = 32'h30000
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rollback,
  mem_ctrl_burst_if.slave bus
);
  localparam int CW = $clog2(LINE_BYTES) + 1;
  localparam int DW = 8 * LINE_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_BUBBLE, S_FETCH, S_LOAD, S_STORE} state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [CW-1:0]     r_nbytes, w_nbytes;
  logic              r_io, w_io;
  logic [31:0]       r_wdata, w_wdata;
  logic [DW-1:0]     r_buf, w_buf;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a;
  logic [7:0]        r_mem_dout, w_mem_dout;
  logic              r_mem_wr, w_mem_wr;
  logic              r_if_done, w_if_done;
  logic              r_lsb_done, w_lsb_done;
  logic [DW-1:0]     r_if_data, w_if_data;
  logic [31:0]       r_lsb_r_data, w_lsb_r_data;
  logic [DW-1:0]     w_merged;
  logic [CW-1:0]     w_lsb_n;

  always_comb begin
    w_lsb_n = CW'(4);
    if (bus.lsb_len == 3'd1)      w_lsb_n = CW'(1);
    else if (bus.lsb_len == 3'd2) w_lsb_n = CW'(2);
  end

  always_comb begin
    w_merged = r_buf;
    w_merged[8*r_cnt[CW-2:0] +: 8] = bus.mem_din;
  end

  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_cnt        = r_cnt;
    w_nbytes     = r_nbytes;
    w_io         = r_io;
    w_wdata      = r_wdata;
    w_buf        = r_buf;
    w_mem_a      = r_mem_a;
    w_mem_dout   = r_mem_dout;
    w_mem_wr     = 1'b0;
    w_if_done    = 1'b0;
    w_lsb_done   = 1'b0;
    w_if_data    = r_if_data;
    w_lsb_r_data = r_lsb_r_data;
    case (r_state)
      S_IDLE: begin
        if (!rollback) begin
          if (bus.lsb_en) begin
            w_addr   = bus.lsb_addr;
            w_nbytes = w_lsb_n;
            w_wdata  = bus.lsb_w_data;
            w_io     = (bus.lsb_addr >= IO_BASE);
            w_cnt    = '0;
            w_buf    = '0;
            if (bus.lsb_wr) begin
              w_state = S_STORE;
            end else begin
              w_state = S_LOAD;
              w_mem_a = bus.lsb_addr;
            end
          end else if (bus.if_en) begin
            w_addr   = bus.if_addr;
            w_nbytes = CW'(LINE_BYTES);
            w_cnt    = '0;
            w_buf    = '0;
            w_mem_a  = bus.if_addr;
            w_state  = S_FETCH;
          end
        end
      end
      S_BUBBLE: w_state = S_IDLE;
      S_FETCH, S_LOAD: begin
        // Abort beats completion: partial data is dropped, no done pulse.
        if (rollback) begin
          w_state = S_IDLE;
          w_mem_a = '0;
        end else begin
          w_buf = w_merged;
          if (r_cnt == r_nbytes - CW'(1)) begin
            w_mem_a = '0;
            w_state = S_BUBBLE;
            if (r_state == S_FETCH) begin
              w_if_done = 1'b1;
              w_if_data = w_merged;
            end else begin
              w_lsb_done   = 1'b1;
              w_lsb_r_data = w_merged[31:0];
            end
          end else begin
            w_cnt   = r_cnt + CW'(1);
            w_mem_a = r_addr + ADDR_W'(r_cnt) + ADDR_W'(1);
          end
        end
      end
      S_STORE: begin
        if (r_cnt == r_nbytes) begin
          w_lsb_done = 1'b1;
          w_mem_a    = '0;
          w_state    = S_BUBBLE;
        end else if (!r_io || !bus.io_buffer_full) begin
          w_mem_wr   = 1'b1;
          w_mem_a    = r_addr + ADDR_W'(r_cnt);
          w_mem_dout = r_wdata[8*r_cnt[1:0] +: 8];
          w_cnt      = r_cnt + CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_nbytes     <= '0;
      r_io         <= 1'b0;
      r_wdata      <= '0;
      r_buf        <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_if_done    <= 1'b0;
      r_lsb_done   <= 1'b0;
      r_if_data    <= '0;
      r_lsb_r_data <= '0;
    end else if (rdy) begin
      r_state      <= w_state;
      r_addr       <= w_addr;
      r_cnt        <= w_cnt;
      r_nbytes     <= w_nbytes;
      r_io         <= w_io;
      r_wdata      <= w_wdata;
      r_buf        <= w_buf;
      r_mem_a      <= w_mem_a;
      r_mem_dout   <= w_mem_dout;
      r_mem_wr     <= w_mem_wr;
      r_if_done    <= w_if_done;
      r_lsb_done   <= w_lsb_done;
      r_if_data    <= w_if_data;
      r_lsb_r_data <= w_lsb_r_data;
    end
  end

  // Strobes are masked while frozen; the held state re-presents them once rdy returns.
  assign bus.mem_a      = r_mem_a;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.mem_wr     = r_mem_wr & rdy;
  assign bus.if_done    = r_if_done & rdy;
  assign bus.lsb_done   = r_lsb_done & rdy;
  assign bus.if_data    = r_if_data;
  assign bus.lsb_r_data = r_lsb_r_data;
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Directed bench for mem_ctrl_burst with an 8-byte line and a behavioural byte RAM (RAM[a] = a[7:0] unless written).
module tb_mem_ctrl_burst;
  localparam int LB = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_ctrl_burst_if #(.LINE_BYTES(LB), .ADDR_W(AW)) bus ();

  mem_ctrl_burst #(.LINE_BYTES(LB), .ADDR_W(AW), .IO_BASE(32'h30000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [bit [31:0]];
  logic [31:0] wr_a_q [$];
  logic [7:0]  wr_d_q [$];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0];
  endfunction

  always @(negedge clk) bus.mem_din <= rd(bus.mem_a);

  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      ram[bus.mem_a] = bus.mem_dout;
      wr_a_q.push_back(bus.mem_a);
      wr_d_q.push_back(bus.mem_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_en = 1'b0;
    bus.if_addr = '0;
    bus.lsb_en = 1'b0;
    bus.lsb_wr = 1'b0;
    bus.lsb_addr = '0;
    bus.lsb_len = 3'd0;
    bus.lsb_w_data = '0;
    tick();
    tick();
    n_cmp++; if (bus.mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
    n_cmp++; if (bus.mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
    n_cmp++; if (bus.if_done !== 1'b0 || bus.lsb_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b%b want 00", bus.if_done, bus.lsb_done); end
    n_cmp++; if (bus.if_data !== 64'h0 || bus.lsb_r_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h/%h want 0", bus.if_data, bus.lsb_r_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus.if_addr = 32'h100;
    bus.if_en = 1'b1;
    tick();
    for (int k = 0; k < LB; k++) begin
      n_cmp++; if (bus.mem_a !== 32'h100 + k || bus.if_done !== 1'b0) begin n_bad++; $display("FAIL fetch_step k=%0d got a=%h done=%b want a=%h done=0", k, bus.mem_a, bus.if_done, 32'h100 + k); end
      tick();
    end
    n_cmp++; if (bus.if_done !== 1'b1) begin n_bad++; $display("FAIL fetch_done got %b want 1", bus.if_done); end
    n_cmp++; if (bus.if_data !== 64'h0706050403020100) begin n_bad++; $display("FAIL fetch_data got %h want 0706050403020100", bus.if_data); end
    n_cmp++; if (bus.mem_a !== 32'h0) begin n_bad++; $display("FAIL fetch_end_a got %h want 0", bus.mem_a); end
    bus.if_en = 1'b0;
    tick();
    n_cmp++; if (bus.if_done !== 1'b0) begin n_bad++; $display("FAIL fetch_bubble got %b want 0", bus.if_done); end
  endtask

  task automatic test_priority();
    bus.if_addr = 32'h200;
    bus.if_en = 1'b1;
    bus.lsb_addr = 32'h20;
    bus.lsb_len = 3'd2;
    bus.lsb_wr = 1'b0;
    bus.lsb_en = 1'b1;
    tick();
    n_cmp++; if (bus.mem_a !== 32'h20) begin n_bad++; $display("FAIL prio_first got %h want 20", bus.mem_a); end
    tick();
    n_cmp++; if (bus.mem_a !== 32'h21) begin n_bad++; $display("FAIL prio_load_a1 got %h want 21", bus.mem_a); end
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b1 || bus.lsb_r_data !== 32'h00002120) begin n_bad++; $display("FAIL prio_load_data got done=%b d=%h want 1/00002120", bus.lsb_done, bus.lsb_r_data); end
    bus.lsb_en = 1'b0;
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b0 || bus.mem_a !== 32'h0 || bus.if_done !== 1'b0) begin n_bad++; $display("FAIL prio_bubble got done=%b a=%h want 0/0", bus.lsb_done, bus.mem_a); end
    tick();
    for (int k = 0; k < LB; k++) begin
      n_cmp++; if (bus.mem_a !== 32'h200 + k) begin n_bad++; $display("FAIL prio_fetch_step k=%0d got %h want %h", k, bus.mem_a, 32'h200 + k); end
      tick();
    end
    n_cmp++; if (bus.if_done !== 1'b1 || bus.if_data !== 64'h0706050403020100) begin n_bad++; $display("FAIL prio_fetch_done got done=%b d=%h want 1/0706050403020100", bus.if_done, bus.if_data); end
    bus.if_en = 1'b0;
    tick();
  endtask

  task automatic test_io_store();
    logic [7:0] exp_d [4];
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wr_a_q.delete();
    wr_d_q.delete();
    bus.lsb_addr = 32'h30000;
    bus.lsb_len = 3'd4;
    bus.lsb_w_data = 32'hDDCCBBAA;
    bus.lsb_wr = 1'b1;
    bus.lsb_en = 1'b1;
    tick();
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL store_accept_wr got %b want 0", bus.mem_wr); end
    tick();
    n_cmp++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h30000 || bus.mem_dout !== 8'hAA) begin n_bad++; $display("FAIL store_b0 got wr=%b a=%h d=%h want 1/30000/aa", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    bus.io_buffer_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_cmp++; if (bus.mem_wr !== 1'b0 || bus.lsb_done !== 1'b0) begin n_bad++; $display("FAIL store_stall s=%0d got wr=%b done=%b want 0/0", s, bus.mem_wr, bus.lsb_done); end
    end
    bus.io_buffer_full = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h30000 + k || bus.mem_dout !== exp_d[k]) begin n_bad++; $display("FAIL store_byte k=%0d got wr=%b a=%h d=%h want 1/%h/%h", k, bus.mem_wr, bus.mem_a, bus.mem_dout, 32'h30000 + k, exp_d[k]); end
    end
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0) begin n_bad++; $display("FAIL store_done got done=%b wr=%b a=%h want 1/0/0", bus.lsb_done, bus.mem_wr, bus.mem_a); end
    bus.lsb_en = 1'b0;
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b0) begin n_bad++; $display("FAIL store_bubble got %b want 0", bus.lsb_done); end
    n_cmp++; if (wr_a_q.size() !== 4) begin n_bad++; $display("FAIL store_count got %0d want 4", wr_a_q.size()); end
    for (int k = 0; k < 4 && k < wr_a_q.size(); k++) begin
      n_cmp++; if (wr_a_q[k] !== 32'h30000 + k || wr_d_q[k] !== exp_d[k]) begin n_bad++; $display("FAIL store_log k=%0d got %h:%h want %h:%h", k, wr_a_q[k], wr_d_q[k], 32'h30000 + k, exp_d[k]); end
    end
  endtask

  task automatic test_rollback();
    bus.lsb_addr = 32'h40;
    bus.lsb_len = 3'd4;
    bus.lsb_wr = 1'b0;
    bus.lsb_en = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.mem_a !== 32'h41) begin n_bad++; $display("FAIL rb_load_a got %h want 41", bus.mem_a); end
    rollback = 1'b1;
    tick();
    n_cmp++; if (bus.mem_a !== 32'h0 || bus.lsb_done !== 1'b0) begin n_bad++; $display("FAIL rb_abort got a=%h done=%b want 0/0", bus.mem_a, bus.lsb_done); end
    rollback = 1'b0;
    bus.lsb_en = 1'b0;
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b0 || bus.mem_a !== 32'h0) begin n_bad++; $display("FAIL rb_idle got done=%b a=%h want 0/0", bus.lsb_done, bus.mem_a); end
    bus.lsb_addr = 32'h55;
    bus.lsb_len = 3'd1;
    bus.lsb_en = 1'b1;
    tick();
    n_cmp++; if (bus.mem_a !== 32'h55) begin n_bad++; $display("FAIL rb_next_a got %h want 55", bus.mem_a); end
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b1 || bus.lsb_r_data !== 32'h00000055) begin n_bad++; $display("FAIL rb_next_data got done=%b d=%h want 1/00000055", bus.lsb_done, bus.lsb_r_data); end
    bus.lsb_en = 1'b0;
    tick();
    wr_a_q.delete();
    wr_d_q.delete();
    bus.lsb_addr = 32'h80;
    bus.lsb_len = 3'd2;
    bus.lsb_w_data = 32'h00001234;
    bus.lsb_wr = 1'b1;
    bus.lsb_en = 1'b1;
    tick();
    rollback = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (bus.lsb_done !== 1'b1) begin n_bad++; $display("FAIL rb_store_done got %b want 1", bus.lsb_done); end
    rollback = 1'b0;
    bus.lsb_en = 1'b0;
    tick();
    n_cmp++; if (wr_a_q.size() !== 2 || wr_d_q[0] !== 8'h34 || wr_a_q[1] !== 32'h81 || wr_d_q[1] !== 8'h12) begin n_bad++; $display("FAIL rb_store_log got n=%0d want 2 writes 80:34 81:12", wr_a_q.size()); end
  endtask

  task automatic test_len_default();
    bus.lsb_addr = 32'h60;
    bus.lsb_len = 3'd7;
    bus.lsb_wr = 1'b0;
    bus.lsb_en = 1'b1;
    repeat (5) tick();
    n_cmp++; if (bus.lsb_done !== 1'b1 || bus.lsb_r_data !== 32'h63626160) begin n_bad++; $display("FAIL len7_load got done=%b d=%h want 1/63626160", bus.lsb_done, bus.lsb_r_data); end
    bus.lsb_en = 1'b0;
    tick();
  endtask

  task automatic test_rdy_freeze();
    int edges;
    bus.if_addr = 32'h300;
    bus.if_en = 1'b1;
    tick();
    edges = 1;
    for (int k = 0; k < LB; k++) begin
      n_cmp++; if (bus.mem_a !== 32'h300 + k || bus.if_done !== 1'b0) begin n_bad++; $display("FAIL rdy_step k=%0d got a=%h done=%b want %h/0", k, bus.mem_a, bus.if_done, 32'h300 + k); end
      if (k == 2) begin
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          edges++;
          n_cmp++; if (bus.mem_a !== 32'h302 || bus.mem_wr !== 1'b0 || bus.if_done !== 1'b0) begin n_bad++; $display("FAIL rdy_hold s=%0d got a=%h wr=%b done=%b want 302/0/0", s, bus.mem_a, bus.mem_wr, bus.if_done); end
        end
        rdy = 1'b1;
      end
      tick();
      edges++;
    end
    n_cmp++; if (bus.if_done !== 1'b1 || edges !== 12) begin n_bad++; $display("FAIL rdy_done got done=%b edges=%0d want 1/12", bus.if_done, edges); end
    n_cmp++; if (bus.if_data !== 64'h0706050403020100) begin n_bad++; $display("FAIL rdy_data got %h want 0706050403020100", bus.if_data); end
    bus.if_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] a;
    bus.lsb_addr = 32'h90;
    bus.lsb_len = 3'd4;
    bus.lsb_w_data = 32'h44332211;
    bus.lsb_wr = 1'b1;
    bus.lsb_en = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL rst_pre_wr got %b want 1", bus.mem_wr); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0 || bus.mem_dout !== 8'h0) begin n_bad++; $display("FAIL rst_async_mem got wr=%b a=%h d=%h want 0/0/0", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    n_cmp++; if (bus.if_data !== 64'h0 || bus.lsb_r_data !== 32'h0 || bus.lsb_done !== 1'b0 || bus.if_done !== 1'b0) begin n_bad++; $display("FAIL rst_async_out got %h/%h want 0/0", bus.if_data, bus.lsb_r_data); end
    bus.lsb_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.mem_a !== 32'h0 || bus.mem_wr !== 1'b0 || bus.lsb_done !== 1'b0) begin n_bad++; $display("FAIL rst_idle got a=%h wr=%b done=%b want 0/0/0", bus.mem_a, bus.mem_wr, bus.lsb_done); end
    bus.if_addr = 32'hFFFFFFFC;
    bus.if_en = 1'b1;
    tick();
    for (int k = 0; k < LB; k++) begin
      a = 32'hFFFFFFFC + k;
      n_cmp++; if (bus.mem_a !== a) begin n_bad++; $display("FAIL wrap_step k=%0d got %h want %h", k, bus.mem_a, a); end
      tick();
    end
    n_cmp++; if (bus.if_done !== 1'b1 || bus.if_data !== 64'h03020100FFFEFDFC) begin n_bad++; $display("FAIL wrap_data got done=%b d=%h want 1/03020100fffefdfc", bus.if_done, bus.if_data); end
    bus.if_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_io_store();
    test_rollback();
    test_len_default();
    test_rdy_freeze();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
